// File: rtl/gpu_fetcher.sv
// gpu_fetcher: instruction fetch unit for a compute-unit core.
// Issues one val/rdy request per FETCH phase of the core, waits for the
// memory response, and holds the captured instruction until the next capture.
module gpu_fetcher #(
  parameter int PC_ADDR_WIDTH  = 8,
  parameter int INST_MSG_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                cu_state,
  input  logic [PC_ADDR_WIDTH-1:0]  curr_pc,
  output logic [1:0]                fetch_state,
  output logic [INST_MSG_WIDTH-1:0] fetch_instr,
  input  logic                      fetch_req_rdy,
  output logic                      fetch_req_val,
  output logic [PC_ADDR_WIDTH-1:0]  fetch_req_addr,
  output logic                      fetch_resp_rdy,
  input  logic                      fetch_resp_val,
  input  logic [INST_MSG_WIDTH-1:0] fetch_resp_inst
);

  localparam logic [3:0] CU_FETCH = 4'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    FETCHED = 2'd3
  } fetch_state_e;

  fetch_state_e state, state_next;
  logic         addr_load;
  logic         instr_load;
  logic         req_fire;
  logic         resp_fire;
  logic         cu_fetch;

  assign cu_fetch  = (cu_state == CU_FETCH);
  assign req_fire  = fetch_req_val  && fetch_req_rdy;
  assign resp_fire = fetch_resp_rdy && fetch_resp_val;

  // Handshake outputs depend only on the current state, never on rdy/val inputs.
  assign fetch_req_val  = (state == REQ);
  assign fetch_resp_rdy = (state == WAIT);
  assign fetch_state    = state;

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and register load enables.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    state_next = state;
    addr_load  = 1'b0;
    instr_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (cu_fetch) begin
          addr_load  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (req_fire) state_next = WAIT;
      end
      WAIT: begin
        if (resp_fire) begin
          instr_load = 1'b1;
          state_next = FETCHED;
        end
      end
      FETCHED: begin
        if (!cu_fetch) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request address is captured once in IDLE and held until the next fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         fetch_req_addr <= '0;
    else if (addr_load) fetch_req_addr <= curr_pc;
  end

  // Instruction register changes only on a response fire in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          fetch_instr <= '0;
    else if (instr_load) fetch_instr <= fetch_resp_inst;
  end

endmodule

// File: tb/tb_gpu_fetcher.sv
// tb_gpu_fetcher: directed and randomized checks of gpu_fetcher against a
// transaction-level reference model kept in the bench.
module tb_gpu_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cu_state = '0;
  logic [7:0]  curr_pc = '0;
  logic [1:0]  fetch_state;
  logic [15:0] fetch_instr;
  logic        fetch_req_rdy = 1'b0;
  logic        fetch_req_val;
  logic [7:0]  fetch_req_addr;
  logic        fetch_resp_rdy;
  logic        fetch_resp_val = 1'b0;
  logic [15:0] fetch_resp_inst = '0;

  int n_checks = 0;
  int n_fail   = 0;

  gpu_fetcher #(.PC_ADDR_WIDTH(8), .INST_MSG_WIDTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .cu_state        (cu_state),
    .curr_pc         (curr_pc),
    .fetch_state     (fetch_state),
    .fetch_instr     (fetch_instr),
    .fetch_req_rdy   (fetch_req_rdy),
    .fetch_req_val   (fetch_req_val),
    .fetch_req_addr  (fetch_req_addr),
    .fetch_resp_rdy  (fetch_resp_rdy),
    .fetch_resp_val  (fetch_resp_val),
    .fetch_resp_inst (fetch_resp_inst)
  );

  always #5 clk = ~clk;

  // Transaction-level model: which step of the fetch transaction is pending,
  // the address being requested, and the last captured instruction.
  bit          m_busy;       // a transaction has been started
  bit          m_req_done;   // request has been accepted by memory
  bit          m_have_inst;  // response received, holding in FETCHED
  logic [7:0]  m_addr;
  logic [15:0] m_instr;

  function automatic logic [1:0] model_state();
    if (!m_busy)          return 2'd0;
    if (m_have_inst)      return 2'd3;
    if (m_req_done)       return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [27:0] model_vec();
    logic [1:0] s;
    s = model_state();
    return {s, s == 2'd1, s == 2'd2, m_addr, m_instr};
  endfunction

  wire [27:0] dut_vec = {fetch_state, fetch_req_val, fetch_resp_rdy,
                         fetch_req_addr, fetch_instr};

  task automatic model_clear();
    m_busy = 0; m_req_done = 0; m_have_inst = 0;
    m_addr = '0; m_instr = '0;
  endtask

  // Advance one clock and apply the transaction rules to the pre-edge inputs;
  // returns at the following falling edge, where outputs are sampled.
  task automatic step();
    logic [1:0] s;
    @(posedge clk);
    s = model_state();
    if (!reset) model_clear();
    else if (!m_busy) begin
      if (cu_state == 4'd1) begin m_busy = 1; m_addr = curr_pc; end
    end else if (m_have_inst) begin
      if (cu_state != 4'd1) begin m_busy = 0; m_req_done = 0; m_have_inst = 0; end
    end else if (!m_req_done) begin
      if (s == 2'd1 && fetch_req_rdy) m_req_done = 1;
    end else if (fetch_resp_val) begin
      m_instr = fetch_resp_inst; m_have_inst = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_clear();
    #3;
    n_checks++;
    if (dut_vec !== 28'd0) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", dut_vec, 28'd0);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) reset = 1'b1;
      step();
      n_checks++;
      if (dut_vec !== 28'd0 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL reset_idle[%0d]: got %h want %h", i, dut_vec, 28'd0);
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0] exp_s [3];
    exp_s = '{2'd1, 2'd2, 2'd3};
    cu_state = 4'd1; curr_pc = 8'h05; fetch_req_rdy = 1; fetch_resp_val = 1;
    fetch_resp_inst = 16'hA1B2;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (fetch_state !== exp_s[i] || dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL basic_seq[%0d]: got state %0d vec %h want state %0d vec %h",
                 i, fetch_state, dut_vec, exp_s[i], model_vec());
      end
    end
    n_checks++;
    if (fetch_req_addr !== 8'h05 || fetch_instr !== 16'hA1B2) begin
      n_fail++; $display("FAIL basic_data: got addr %h instr %h want 05 A1B2",
                         fetch_req_addr, fetch_instr);
    end
    cu_state = 4'd0; fetch_req_rdy = 0; fetch_resp_val = 0;
    step();
    n_checks++;
    if (fetch_state !== 2'd0) begin
      n_fail++; $display("FAIL basic_exit: got state %0d want 0", fetch_state);
    end
  endtask

  task automatic test_req_stall();
    cu_state = 4'd1; curr_pc = 8'h05; fetch_req_rdy = 0; fetch_resp_val = 0;
    step();
    cu_state = 4'd0; curr_pc = 8'h33;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (fetch_state !== 2'd1 || fetch_req_val !== 1'b1 || fetch_req_addr !== 8'h05
          || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL req_stall[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
    fetch_req_rdy = 1;
    step();
    fetch_req_rdy = 0;
    n_checks++;
    if (fetch_state !== 2'd2 || fetch_resp_rdy !== 1'b1 || fetch_req_val !== 1'b0) begin
      n_fail++; $display("FAIL req_fire: got state %0d want 2", fetch_state);
    end
  endtask

  task automatic test_wait_stall();
    fetch_resp_val = 0; curr_pc = 8'h09; cu_state = 4'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (fetch_state !== 2'd2 || fetch_req_addr !== 8'h05 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL wait_stall[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
    fetch_resp_val = 1; fetch_resp_inst = 16'h1234;
    step();
    fetch_resp_val = 0;
    n_checks++;
    if (fetch_state !== 2'd3 || fetch_instr !== 16'h1234) begin
      n_fail++; $display("FAIL wait_fire: got state %0d instr %h want 3 1234",
                         fetch_state, fetch_instr);
    end
  endtask

  task automatic test_fetched_hold();
    cu_state = 4'd1; fetch_resp_val = 1; fetch_resp_inst = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (fetch_state !== 2'd3 || fetch_instr !== 16'h1234 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL fetched_hold[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
    cu_state = 4'd2;
    step();
    n_checks++;
    if (fetch_state !== 2'd0 || fetch_instr !== 16'h1234) begin
      n_fail++; $display("FAIL fetched_exit: got state %0d instr %h want 0 1234",
                         fetch_state, fetch_instr);
    end
    step();
    fetch_resp_val = 0;
    n_checks++;
    if (fetch_instr !== 16'h1234 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL idle_ignore_resp: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    cu_state = 4'd1; curr_pc = 8'h07; fetch_req_rdy = 1; fetch_resp_val = 0;
    step();
    step();
    n_checks++;
    if (fetch_state !== 2'd2) begin
      n_fail++; $display("FAIL reset_mid_setup: got state %0d want 2", fetch_state);
    end
    #2 reset = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (dut_vec !== 28'd0) begin
      n_fail++; $display("FAIL reset_mid_async: got %h want 0", dut_vec);
    end
    cu_state = 4'd0; fetch_resp_val = 1; fetch_resp_inst = 16'hBEEF;
    step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (fetch_state !== 2'd0 || fetch_instr !== 16'h0000 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL reset_late_resp[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
    fetch_resp_val = 0; fetch_req_rdy = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 59) != 0);
      cu_state        = ($urandom_range(0, 2) != 0) ? 4'd1 : 4'($urandom);
      curr_pc         = 8'($urandom);
      fetch_req_rdy   = 1'($urandom);
      fetch_resp_val  = 1'($urandom);
      fetch_resp_inst = 16'($urandom);
      step();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_wait_stall();
    test_fetched_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
